datapath: RTL and testbench

- 32-bit single-bus CPU datapath: general registers R0–R15, HI, LO, Y, 64-bit Z, PC, IR, MAR, MDR, Inport and C, all on one shared bus, plus an ALU.
- An external control unit, or a bench acting as one, drives every register-in enable, bus-out select, ALU opcode and memory-read strobe directly.
- Sits under the CPU top level, below the control unit.

---
 rtl/datapath.sv | 137 +++++++++++++
 tb/tb_datapath.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// rtl/datapath.sv - 32-bit single-bus CPU datapath with register file, 64-bit Z and ALU
//
// Ports:
//   Clock                      rising-edge clock for every register
//   clear                      asynchronous active-high reset, zeroes all registers
//   Read                       MDR input select: 1 = Mdatain, 0 = bus
//   IncPC                      forces ALU result to {32'h0, bus + 1}
//   opcode[4:0]                ALU operation select
//   R0in..R15in, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin
//                              register load enables
//   R0out..R15out, HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
//   MDRout, Inportout, Cout    bus source selects
//   Mdatain[31:0]              memory read data
module datapath (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin,
  input  logic        R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
  input  logic        MDRout, Inportout, Cout,
  input  logic [31:0] Mdatain
);

  logic [15:0] r_in;
  logic [15:0] r_out;
  logic [31:0] r [16];
  logic [31:0] hi, lo, y, pc, ir, mar, mdr, inport, c;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] alu;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Bus mux: sources are assigned lowest priority first so the highest
  // priority active select is the one that sticks.
  always_comb begin
    bus = 32'h0;
    if (MARout)    bus = mar;
    if (IRout)     bus = ir;
    if (Yout)      bus = y;
    if (Cout)      bus = c;
    if (Inportout) bus = inport;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (Zlowout)   bus = z[31:0];
    if (Zhighout)  bus = z[63:32];
    if (LOout)     bus = lo;
    if (HIout)     bus = hi;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r[i];
    end
  end

  // ALU helpers: A = Y, B = bus; shift amounts use B[4:0] only.
  logic [4:0]         sh;
  logic signed [31:0] sa, sb;
  logic [31:0]        ror_w, rol_w, quo, rem;
  logic [63:0]        prod;

  assign sh    = bus[4:0];
  assign sa    = $signed(y);
  assign sb    = $signed(bus);
  // Rotates shift a doubled copy of A and keep the relevant half.
  assign ror_w = 32'({y, y} >> sh);
  assign rol_w = 32'(({y, y} << sh) >> 32);
  // Sign-extend both operands to 64 bits; the low 64 bits of the unsigned
  // product then equal the signed product.
  assign prod  = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
  // Signed / and % truncate toward zero, so the remainder follows the dividend.
  assign quo   = (bus == 32'h0) ? 32'hFFFF_FFFF : $unsigned(sa / sb);
  assign rem   = (bus == 32'h0) ? y             : $unsigned(sa % sb);

  always_comb begin
    alu = 64'h0;
    if (IncPC) begin
      alu[31:0] = bus + 32'd1;
    end else begin
      case (opcode)
        5'b00000, 5'b00001, 5'b00010,
        5'b00011, 5'b01100: alu[31:0] = y + bus;
        5'b00100:           alu[31:0] = y - bus;
        5'b00101:           alu[31:0] = y >> sh;
        5'b00110:           alu[31:0] = $unsigned(sa >>> sh);
        5'b00111:           alu[31:0] = y << sh;
        5'b01000:           alu[31:0] = ror_w;
        5'b01001:           alu[31:0] = rol_w;
        5'b01010, 5'b01101: alu[31:0] = y & bus;
        5'b01011, 5'b01110: alu[31:0] = y | bus;
        5'b01111:           alu       = prod;
        5'b10000:           alu       = {rem, quo};
        5'b10001:           alu[31:0] = 32'h0 - bus;
        5'b10010:           alu[31:0] = ~bus;
        default:            alu       = 64'h0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r[i] <= 32'h0;
      hi     <= 32'h0;
      lo     <= 32'h0;
      y      <= 32'h0;
      z      <= 64'h0;
      pc     <= 32'h0;
      ir     <= 32'h0;
      mar    <= 32'h0;
      mdr    <= 32'h0;
      inport <= 32'h0;
      c      <= 32'h0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r[i] <= bus;
      end
      if (HIin)     hi     <= bus;
      if (LOin)     lo     <= bus;
      if (Yin)      y      <= bus;
      if (Zin)      z      <= alu;
      if (PCin)     pc     <= bus;
      if (IRin)     ir     <= bus;
      if (MARin)    mar    <= bus;
      if (MDRin)    mdr    <= Read ? Mdatain : bus;
      if (Inportin) inport <= bus;
      if (Cin)      c      <= bus;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath driven as a control unit
module tb_datapath;

  logic        Clock, clear, Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] rin, rout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout;
  logic        MDRout, Inportout, Cout;
  logic [31:0] Mdatain;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
    .Inportout(Inportout), .Cout(Cout), .Mdatain(Mdatain)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'h1, 64'h0);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic idle();
    Read = 0; IncPC = 0; opcode = 5'b0; rin = '0; rout = '0;
    {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin} = '0;
    {HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout} = '0;
  endtask

  // Controls are driven 1 time unit after an edge and cleared after the next.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] val);
    Mdatain = val; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_r(input int n, input logic [31:0] val);
    mem_to_mdr(val);
    MDRout = 1; rin[n] = 1;
    tick();
  endtask

  task automatic alu_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [63:0] expz);
    mem_to_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    mem_to_mdr(b);
    MDRout = 1; opcode = op; Zin = 1;
    push_exp(tag, expz);
    tick();
    pop_check(dut.z);
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    clear = 0;
    #1 clear = 1;
    #1;
    check("reset_pc", {32'h0, dut.pc}, 64'h0);
    check("reset_z", dut.z, 64'h0);
    check("reset_r0", {32'h0, dut.r[0]}, 64'h0);
    check("reset_r15", {32'h0, dut.r[15]}, 64'h0);
    check("bus_idle", {32'h0, dut.bus}, 64'h0);
    @(negedge Clock) clear = 0;
    @(posedge Clock) #1;

    // 1: load and rol by 34 (behaves as 2)
    load_r(2, 32'd1);
    load_r(3, 32'd34);
    load_r(1, 32'd8);
    check("load_r1", {32'h0, dut.r[1]}, 64'd8);
    rout[2] = 1; Yin = 1;
    tick();
    rout[3] = 1; opcode = 5'b01001; Zin = 1;
    push_exp("rol_z", 64'h4);
    tick();
    pop_check(dut.z);
    Zlowout = 1; rin[1] = 1;
    tick();
    check("rol_r1", {32'h0, dut.r[1]}, 64'h4);

    // 2: instruction fetch
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    tick();
    check("fetch_mar", {32'h0, dut.mar}, 64'h0);
    Zlowout = 1; PCin = 1;
    tick();
    check("fetch_pc", {32'h0, dut.pc}, 64'h1);
    mem_to_mdr(32'h18918000);
    MDRout = 1; IRin = 1;
    tick();
    check("fetch_ir", {32'h0, dut.ir}, 64'h18918000);

    // 3..5: ALU operations
    alu_run("add",      32'd7,        32'd5,  5'b00011, 64'd12);
    alu_run("sub",      32'd7,        32'd5,  5'b00100, 64'd2);
    alu_run("sub_neg",  32'd0,        32'd1,  5'b00100, 64'h0000_0000_FFFF_FFFF);
    alu_run("addi_wrap",32'hFFFFFFFF, 32'd2,  5'b01100, 64'h1);
    alu_run("mul",      32'hFFFFFFFA, 32'd4,  5'b01111, 64'hFFFF_FFFF_FFFF_FFE8);
    alu_run("div",      32'd17,       32'd5,  5'b10000, 64'h0000_0002_0000_0003);
    alu_run("div_neg",  32'hFFFFFFEF, 32'd5,  5'b10000, 64'hFFFF_FFFE_FFFF_FFFD);
    alu_run("div_zero", 32'd17,       32'd0,  5'b10000, 64'h0000_0011_FFFF_FFFF);
    alu_run("shr",      32'h80000001, 32'd1,  5'b00101, 64'h4000_0000);
    alu_run("shra",     32'h80000001, 32'd1,  5'b00110, 64'hC000_0000);
    alu_run("shl",      32'h80000001, 32'd1,  5'b00111, 64'h0000_0002);
    alu_run("ror",      32'h80000001, 32'd1,  5'b01000, 64'hC000_0000);
    alu_run("rol",      32'h80000001, 32'd1,  5'b01001, 64'h0000_0003);
    alu_run("shl_34",   32'h00000003, 32'd34, 5'b00111, 64'h0000_000C);
    alu_run("and",      32'hF0F0F0F0, 32'hFF00FF00, 5'b01010, 64'hF000_F000);
    alu_run("or",       32'hF0F0F0F0, 32'h0F000000, 5'b01110, 64'hFFF0_F0F0);
    alu_run("neg",      32'd9,        32'd1,  5'b10001, 64'hFFFF_FFFF);
    alu_run("not",      32'd9,        32'h0000FFFF, 5'b10010, 64'hFFFF_0000);
    alu_run("undef",    32'd9,        32'd3,  5'b11111, 64'h0);

    // 6: clear mid-cycle with Zin high, then bus arbitration
    rout[2] = 1; Zin = 1; opcode = 5'b00011;
    #2 clear = 1;
    #1;
    check("clr_z", dut.z, 64'h0);
    check("clr_r1", {32'h0, dut.r[1]}, 64'h0);
    check("clr_pc", {32'h0, dut.pc}, 64'h0);
    check("clr_ir", {32'h0, dut.ir}, 64'h0);
    @(posedge Clock) #1;
    check("clr_dominates", dut.z, 64'h0);
    clear = 0;
    idle();
    load_r(2, 32'd1);
    load_r(3, 32'd34);
    rout[2] = 1; rout[3] = 1; Yin = 1;
    tick();
    check("arb_r2_r3", {32'h0, dut.y}, 64'h1);
    load_r(0, 32'hA5A5A5A5);
    rout[0] = 1; HIout = 1; MARout = 1; Yin = 1;
    tick();
    check("arb_r0", {32'h0, dut.y}, 64'hA5A5A5A5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
